// File: rtl/mux_rr_arbiter_if.sv
// Bundle for the shared 4:1 mux: requests and data inputs in,
// registered grant/select/busy and muxed data out.
interface mux_rr_arbiter_if #(
  parameter int WIDTH = 1
);
  logic [3:0]       req;
  logic [WIDTH-1:0] data_a;
  logic [WIDTH-1:0] data_b;
  logic [WIDTH-1:0] data_c;
  logic [WIDTH-1:0] data_d;
  logic [3:0]       gnt;
  logic [1:0]       sel;
  logic             busy;
  logic [WIDTH-1:0] data_out;

  modport master (
    output req, data_a, data_b, data_c, data_d,
    input  gnt, sel, busy, data_out
  );

  modport slave (
    input  req, data_a, data_b, data_c, data_d,
    output gnt, sel, busy, data_out
  );
endinterface

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter for the shared 4:1 data mux, with grant bursts
// bounded to MAX_HOLD cycles while other requesters are waiting.
//
// state | meaning
// IDLE  | no owner; gnt=0, busy=0, sel keeps last owner
// GRANT | owner = sel; hold_cnt counts cycles of the current burst
module mux_rr_arbiter #(
  parameter int WIDTH    = 1,
  parameter int MAX_HOLD = 4
) (
  input logic            clk,
  input logic            rst_n,
  mux_rr_arbiter_if.slave bus
);
  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] GRANT = 1'b1;

  localparam int          HW       = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [HW-1:0] HOLD_TOP = HW'(MAX_HOLD - 1);

  logic [0:0]    state_q, state_d;
  logic [3:0]    gnt_q, gnt_d;
  logic [1:0]    sel_q, sel_d;
  logic          busy_q, busy_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [1:0]    last_q, last_d;

  logic          take;
  logic [3:0]    cand;
  logic [3:0]    others;
  logic [1:0]    win;

  // Search order base+1, base+2, base+3, base; the first set bit wins.
  function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] base);
    logic [1:0] idx;
    logic [1:0] w;
    logic       found;
    w     = base;
    found = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      idx = base + 2'(i);
      if (!found && r[idx]) begin
        w     = idx;
        found = 1'b1;
      end
    end
    return w;
  endfunction

  assign others = bus.req & ~(4'b0001 << sel_q);
  assign win    = rr_pick(cand, last_q);

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    sel_d   = sel_q;
    busy_d  = busy_q;
    hold_d  = hold_q;
    last_d  = last_q;
    take    = 1'b0;
    cand    = 4'b0000;

    if (state_q == IDLE) begin
      if (|bus.req) begin
        take = 1'b1;
        cand = bus.req;
      end
    end else if (!bus.req[sel_q]) begin
      if (|others) begin
        take = 1'b1;
        cand = others;
      end else begin
        state_d = IDLE;
        gnt_d   = 4'b0000;
        busy_d  = 1'b0;
        hold_d  = '0;
      end
    end else if (hold_q == HOLD_TOP) begin
      // Burst limit reached: hand over if anyone waits, else restart the count.
      if (|others) begin
        take = 1'b1;
        cand = others;
      end else begin
        hold_d = '0;
      end
    end else begin
      hold_d = hold_q + HW'(1);
    end

    if (take) begin
      state_d = GRANT;
      gnt_d   = 4'b0001 << win;
      sel_d   = win;
      busy_d  = 1'b1;
      last_d  = win;
      hold_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      gnt_q   <= 4'b0000;
      sel_q   <= 2'b00;
      busy_q  <= 1'b0;
      hold_q  <= '0;
      last_q  <= 2'd3;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      sel_q   <= sel_d;
      busy_q  <= busy_d;
      hold_q  <= hold_d;
      last_q  <= last_d;
    end
  end

  logic [WIDTH-1:0] mux_out;

  always_comb begin
    mux_out = '0;
    case (sel_q)
      2'b00:   mux_out = bus.data_a;
      2'b01:   mux_out = bus.data_b;
      2'b10:   mux_out = bus.data_c;
      default: mux_out = bus.data_d;
    endcase
  end

  assign bus.gnt      = gnt_q;
  assign bus.sel      = sel_q;
  assign bus.busy     = busy_q;
  assign bus.data_out = busy_q ? mux_out : '0;
endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Directed bench for mux_rr_arbiter: reset, lone grant, rotation,
// early release, mid-burst reset and burst-limit handover.
module tb_mux_rr_arbiter;
  localparam int WIDTH = 4;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  mux_rr_arbiter_if #(.WIDTH(WIDTH)) bus();

  mux_rr_arbiter #(.WIDTH(WIDTH), .MAX_HOLD(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [WIDTH-1:0] exp_data(input logic [1:0] s, input logic b);
    logic [WIDTH-1:0] v;
    case (s)
      2'b00:   v = 4'h3;
      2'b01:   v = 4'h5;
      2'b10:   v = 4'h1;
      default: v = 4'h9;
    endcase
    return b ? v : '0;
  endfunction

  // Inputs change and outputs are sampled on the falling edge.
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.req = 4'hF;
    tick();
    tick();
    checks++;
    if ({bus.gnt, bus.sel, bus.busy, bus.data_out} !== {4'b0000, 2'b00, 1'b0, 4'h0}) begin
      errors++;
      $display("FAIL reset: gnt=%b sel=%b busy=%b data_out=%h, want 0000/00/0/0",
               bus.gnt, bus.sel, bus.busy, bus.data_out);
    end
    bus.req = 4'h0;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single();
    bus.req = 4'b0100;
    for (int i = 0; i < 9; i++) begin
      tick();
      checks++;
      if ({bus.gnt, bus.sel, bus.busy, bus.data_out} !== {4'b0100, 2'b10, 1'b1, 4'h1}) begin
        errors++;
        $display("FAIL single cyc%0d: gnt=%b sel=%b busy=%b data_out=%h, want 0100/10/1/1",
                 i, bus.gnt, bus.sel, bus.busy, bus.data_out);
      end
    end
    bus.req = 4'b0000;
    tick();
    checks++;
    if ({bus.gnt, bus.sel, bus.busy, bus.data_out} !== {4'b0000, 2'b10, 1'b0, 4'h0}) begin
      errors++;
      $display("FAIL single_release: gnt=%b sel=%b busy=%b data_out=%h, want 0000/10/0/0",
               bus.gnt, bus.sel, bus.busy, bus.data_out);
    end
  endtask

  task automatic test_round_robin();
    logic [1:0] o;
    logic [3:0] g;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    bus.req = 4'hF;
    for (int k = 0; k < 20; k++) begin
      tick();
      o = 2'((k / 4) % 4);
      g = 4'b0001 << o;
      checks++;
      if ({bus.gnt, bus.sel, bus.busy, bus.data_out} !== {g, o, 1'b1, exp_data(o, 1'b1)}) begin
        errors++;
        $display("FAIL round_robin cyc%0d: gnt=%b sel=%b busy=%b data_out=%h, want %b/%b/1/%h",
                 k, bus.gnt, bus.sel, bus.busy, bus.data_out, g, o, exp_data(o, 1'b1));
      end
    end
    bus.req = 4'h0;
    tick();
    checks++;
    if ({bus.gnt, bus.busy} !== {4'b0000, 1'b0}) begin
      errors++;
      $display("FAIL round_robin_idle: gnt=%b busy=%b, want 0000/0", bus.gnt, bus.busy);
    end
  endtask

  task automatic test_early_release();
    // last owner is 0, so 1 wins the 1010 pair
    bus.req = 4'b1010;
    tick();
    tick();
    checks++;
    if ({bus.gnt, bus.sel, bus.busy, bus.data_out} !== {4'b0010, 2'b01, 1'b1, 4'h5}) begin
      errors++;
      $display("FAIL early_owner: gnt=%b sel=%b busy=%b data_out=%h, want 0010/01/1/5",
               bus.gnt, bus.sel, bus.busy, bus.data_out);
    end
    bus.req = 4'b1000;
    tick();
    checks++;
    if ({bus.gnt, bus.sel, bus.busy, bus.data_out} !== {4'b1000, 2'b11, 1'b1, 4'h9}) begin
      errors++;
      $display("FAIL early_handover: gnt=%b sel=%b busy=%b data_out=%h, want 1000/11/1/9",
               bus.gnt, bus.sel, bus.busy, bus.data_out);
    end
    bus.req = 4'b0000;
    tick();
    checks++;
    if ({bus.gnt, bus.sel, bus.busy, bus.data_out} !== {4'b0000, 2'b11, 1'b0, 4'h0}) begin
      errors++;
      $display("FAIL early_idle: gnt=%b sel=%b busy=%b data_out=%h, want 0000/11/0/0",
               bus.gnt, bus.sel, bus.busy, bus.data_out);
    end
  endtask

  task automatic test_mid_reset();
    bus.req = 4'b0100;
    tick();
    tick();
    checks++;
    if (bus.gnt !== 4'b0100) begin
      errors++;
      $display("FAIL midrst_owner: gnt=%b, want 0100", bus.gnt);
    end
    rst_n = 1'b0;
    tick();
    checks++;
    if ({bus.gnt, bus.sel, bus.busy, bus.data_out} !== {4'b0000, 2'b00, 1'b0, 4'h0}) begin
      errors++;
      $display("FAIL midrst_drop: gnt=%b sel=%b busy=%b data_out=%h, want 0000/00/0/0",
               bus.gnt, bus.sel, bus.busy, bus.data_out);
    end
    rst_n = 1'b1;
    bus.req = 4'b0101;
    tick();
    checks++;
    if ({bus.gnt, bus.sel, bus.busy, bus.data_out} !== {4'b0001, 2'b00, 1'b1, 4'h3}) begin
      errors++;
      $display("FAIL midrst_regrant: gnt=%b sel=%b busy=%b data_out=%h, want 0001/00/1/3",
               bus.gnt, bus.sel, bus.busy, bus.data_out);
    end
    bus.req = 4'b0000;
    tick();
  endtask

  task automatic test_back_to_back();
    // Lone requester 0 keeps the grant across hold-count wraps.
    bus.req = 4'b0001;
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if ({bus.gnt, bus.sel, bus.busy} !== {4'b0001, 2'b00, 1'b1}) begin
        errors++;
        $display("FAIL lone cyc%0d: gnt=%b sel=%b busy=%b, want 0001/00/1",
                 i, bus.gnt, bus.sel, bus.busy);
      end
    end
    // Burst count is now 1: two more cycles for owner 0, then handover to 2.
    bus.req = 4'b0101;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if (bus.gnt !== 4'b0001) begin
        errors++;
        $display("FAIL wrap_hold cyc%0d: gnt=%b, want 0001", i, bus.gnt);
      end
    end
    tick();
    checks++;
    if ({bus.gnt, bus.sel, bus.busy, bus.data_out} !== {4'b0100, 2'b10, 1'b1, 4'h1}) begin
      errors++;
      $display("FAIL wrap_preempt: gnt=%b sel=%b busy=%b data_out=%h, want 0100/10/1/1",
               bus.gnt, bus.sel, bus.busy, bus.data_out);
    end
    bus.req = 4'b0000;
    tick();
    checks++;
    if ({bus.gnt, bus.busy} !== {4'b0000, 1'b0}) begin
      errors++;
      $display("FAIL final_idle: gnt=%b busy=%b, want 0000/0", bus.gnt, bus.busy);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    bus.req = 4'h0;
    bus.data_a = 4'h3;
    bus.data_b = 4'h5;
    bus.data_c = 4'h1;
    bus.data_d = 4'h9;
    test_reset();
    test_single();
    test_round_robin();
    test_early_release();
    test_mid_reset();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
